// File: rtl/fetch_pair_xe.sv
// rtl/fetch_pair_xe.sv - pairs 8Exx/CExx prefix words with their opcode word for decode
// One-entry registered output; a held prefix that cannot pair is emitted as a fault.
module fetch_pair_xe #(
  parameter bit PFX_CE_EN = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic [15:0] inWord,
  input  logic [31:0] inPc,
  input  logic        inValid,
  output logic        inReady,
  output logic [31:0] outWord,
  output logic [31:0] outPc,
  output logic        outPair,
  output logic        outFault,
  output logic        outValid,
  input  logic        outReady
);

  typedef enum logic {
    IDLE = 1'b0,
    PFX  = 1'b1
  } state_t;

  state_t      state;
  state_t      nextState;
  logic [15:0] pfxWord;
  logic [31:0] pfxPc;

  logic        isPfx;
  logic        canLoad;
  logic        brkCond;
  logic        accept;
  logic        load;
  logic        capture;
  logic [31:0] loadWord;
  logic [31:0] loadPc;
  logic        loadPair;
  logic        loadFault;

  always_comb begin
    isPfx     = (inWord[15:8] == 8'h8E) || (PFX_CE_EN && (inWord[15:8] == 8'hCE));
    canLoad   = !outValid || outReady;
    // break condition deliberately excludes inValid so inReady has no path from it
    brkCond   = (state == PFX) && (isPfx || (inPc != (pfxPc + 32'd2)));
    inReady   = reset && !flush && canLoad && !brkCond;
    accept    = inValid && inReady;
    nextState = state;
    load      = 1'b0;
    capture   = 1'b0;
    loadWord  = 32'h0;
    loadPc    = 32'h0;
    loadPair  = 1'b0;
    loadFault = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (isPfx) begin
            capture   = 1'b1;
            nextState = PFX;
          end else begin
            load     = 1'b1;
            loadWord = {inWord, 16'h0000};
            loadPc   = inPc;
          end
        end
      end
      PFX: begin
        if (inValid && brkCond && canLoad) begin
          // orphan prefix goes out alone; the breaking word is re-presented next cycle
          load      = 1'b1;
          loadWord  = {16'h0000, pfxWord};
          loadPc    = pfxPc;
          loadFault = 1'b1;
          nextState = IDLE;
        end else if (accept) begin
          load      = 1'b1;
          loadWord  = {inWord, pfxWord};
          loadPc    = pfxPc;
          loadPair  = 1'b1;
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= IDLE;
      pfxWord  <= 16'h0;
      pfxPc    <= 32'h0;
      outValid <= 1'b0;
      outWord  <= 32'h0;
      outPc    <= 32'h0;
      outPair  <= 1'b0;
      outFault <= 1'b0;
    end else if (flush) begin
      state    <= IDLE;
      outValid <= 1'b0;
    end else begin
      state <= nextState;
      if (capture) begin
        pfxWord <= inWord;
        pfxPc   <= inPc;
      end
      if (load) begin
        outValid <= 1'b1;
        outWord  <= loadWord;
        outPc    <= loadPc;
        outPair  <= loadPair;
        outFault <= loadFault;
      end else if (outReady) begin
        outValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_pair_xe.sv
// tb/tb_fetch_pair_xe.sv - directed and random bench for fetch_pair_xe, both prefix modes
module tb_fetch_pair_xe;

  logic        clock;
  logic        reset;
  logic        flush;
  logic [15:0] inWord;
  logic [31:0] inPc;
  logic        inValid;
  logic        outReady;

  logic        inReady0, inReady1;
  logic [31:0] outWord0, outWord1, outPc0, outPc1;
  logic        outPair0, outPair1, outFault0, outFault1, outValid0, outValid1;

  int checks = 0;
  int failures = 0;

  // reference model state, index 0 = CExx is a prefix, index 1 = only 8Exx
  logic        mHeld[2];
  logic [15:0] mPfxW[2];
  logic [31:0] mPfxPc[2];
  logic        mOV[2];
  logic [31:0] mOW[2];
  logic [31:0] mOPc[2];
  logic        mOPair[2];
  logic        mOFault[2];
  logic        lastRdy[2];
  logic        obsRdy0;

  fetch_pair_xe #(.PFX_CE_EN(1'b1)) u0 (
    .clock(clock), .reset(reset), .flush(flush), .inWord(inWord), .inPc(inPc),
    .inValid(inValid), .inReady(inReady0), .outWord(outWord0), .outPc(outPc0),
    .outPair(outPair0), .outFault(outFault0), .outValid(outValid0), .outReady(outReady)
  );

  fetch_pair_xe #(.PFX_CE_EN(1'b0)) u1 (
    .clock(clock), .reset(reset), .flush(flush), .inWord(inWord), .inPc(inPc),
    .inValid(inValid), .inReady(inReady1), .outWord(outWord1), .outPc(outPc1),
    .outPair(outPair1), .outFault(outFault1), .outValid(outValid1), .outReady(outReady)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic isPfxM(input logic [15:0] w, input int k);
    return (w[15:8] == 8'h8E) || (k == 0 && w[15:8] == 8'hCE);
  endfunction

  task automatic drive(input logic r, input logic f, input logic v, input logic [15:0] w,
                       input logic [31:0] pc, input logic ordy);
    logic held, canL, brk, rdyExp, ld;
    @(negedge clock);
    reset = r; flush = f; inValid = v; inWord = w; inPc = pc; outReady = ordy;
    #1;
    obsRdy0 = inReady0;
    for (int k = 0; k < 2; k++) begin
      held   = mHeld[k];
      canL   = !mOV[k] || ordy;
      brk    = held && (isPfxM(w, k) || pc != mPfxPc[k] + 32'd2);
      rdyExp = r && !f && canL && !brk;
      if (v) checkVal($sformatf("inReady%0d", k), (k == 0) ? inReady0 : inReady1, rdyExp);
      lastRdy[k] = v && rdyExp;
      if (!r) begin
        mHeld[k] = 0; mPfxW[k] = 0; mPfxPc[k] = 0; mOV[k] = 0;
        mOW[k] = 0; mOPc[k] = 0; mOPair[k] = 0; mOFault[k] = 0;
      end else if (f) begin
        mHeld[k] = 0; mOV[k] = 0;
      end else begin
        ld = 0;
        if (held && v && brk && canL) begin
          ld = 1; mOW[k] = {16'h0000, mPfxW[k]}; mOPc[k] = mPfxPc[k];
          mOPair[k] = 0; mOFault[k] = 1; mHeld[k] = 0;
        end else if (v && rdyExp) begin
          if (held) begin
            ld = 1; mOW[k] = {w, mPfxW[k]}; mOPc[k] = mPfxPc[k];
            mOPair[k] = 1; mOFault[k] = 0; mHeld[k] = 0;
          end else if (isPfxM(w, k)) begin
            mHeld[k] = 1; mPfxW[k] = w; mPfxPc[k] = pc;
          end else begin
            ld = 1; mOW[k] = {w, 16'h0000}; mOPc[k] = pc; mOPair[k] = 0; mOFault[k] = 0;
          end
        end
        if (ld) mOV[k] = 1;
        else if (ordy) mOV[k] = 0;
      end
    end
    @(posedge clock);
    #1;
    for (int k = 0; k < 2; k++) begin
      checkVal($sformatf("outValid%0d", k), (k == 0) ? outValid0 : outValid1, mOV[k]);
      if (mOV[k]) begin
        checkVal($sformatf("outWord%0d", k), (k == 0) ? outWord0 : outWord1, mOW[k]);
        checkVal($sformatf("outPc%0d", k), (k == 0) ? outPc0 : outPc1, mOPc[k]);
        checkVal($sformatf("outPair%0d", k), (k == 0) ? outPair0 : outPair1, mOPair[k]);
        checkVal($sformatf("outFault%0d", k), (k == 0) ? outFault0 : outFault1, mOFault[k]);
      end
    end
  endtask

  function automatic logic [15:0] genWord();
    logic [15:0] w;
    w = 16'($urandom);
    case ($urandom_range(0, 3))
      0: w[15:8] = 8'h8E;
      1: w[15:8] = 8'hCE;
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    logic [15:0] curW;
    logic [31:0] curPc;
    logic r, f, v, o;
    for (int k = 0; k < 2; k++) begin
      mHeld[k] = 0; mPfxW[k] = 0; mPfxPc[k] = 0; mOV[k] = 0;
      mOW[k] = 0; mOPc[k] = 0; mOPair[k] = 0; mOFault[k] = 0; lastRdy[k] = 0;
    end
    reset = 0; flush = 0; inValid = 0; inWord = 0; inPc = 0; outReady = 1;

    // reset with input offered
    drive(0, 0, 1, 16'h6012, 32'h1000, 1);
    drive(0, 0, 1, 16'h6012, 32'h1000, 1);
    checkVal("rstInReady", obsRdy0, 0);
    checkVal("rstOutValid", outValid0, 0);
    checkVal("rstOutWord", outWord0, 0);
    checkVal("rstOutPc", outPc0, 0);
    checkVal("rstPairFault", {outPair0, outFault0}, 0);

    drive(1, 0, 1, 16'h6012, 32'h1000, 1);
    checkVal("singleWord", outWord0, 32'h60120000);
    checkVal("singlePc", outPc0, 32'h1000);
    checkVal("singlePair", {outPair0, outFault0}, 0);

    drive(1, 0, 1, 16'h8E05, 32'h2000, 1);
    checkVal("pairFirstNoOut", outValid0, 0);
    drive(1, 0, 1, 16'h3408, 32'h2002, 1);
    checkVal("pairWord", outWord0, 32'h34088E05);
    checkVal("pairPc", outPc0, 32'h2000);
    checkVal("pairFlag", outPair0, 1);

    drive(1, 0, 1, 16'h8E01, 32'h3000, 1);
    drive(1, 0, 1, 16'hCE02, 32'h3002, 1);
    checkVal("pfxPfxStall", obsRdy0, 0);
    checkVal("pfxPfxFaultWord", outWord0, 32'h00008E01);
    checkVal("pfxPfxFault", outFault0, 1);
    checkVal("pfxPfxFaultPc", outPc0, 32'h3000);
    checkVal("noCeWord", outWord1, 32'hCE028E01);
    checkVal("noCePair", outPair1, 1);
    drive(1, 0, 1, 16'hCE02, 32'h3002, 1);
    checkVal("ce02Taken", obsRdy0, 1);
    drive(1, 0, 1, 16'h1234, 32'h3004, 1);
    checkVal("cePairWord", outWord0, 32'h1234CE02);
    checkVal("cePairPc", outPc0, 32'h3002);
    checkVal("cePairFlag", outPair0, 1);

    drive(1, 0, 1, 16'h8E10, 32'h5000, 1);
    drive(1, 0, 1, 16'h2009, 32'h6000, 1);
    checkVal("discFaultWord", outWord0, 32'h00008E10);
    checkVal("discFault", outFault0, 1);
    drive(1, 0, 1, 16'h2009, 32'h6000, 1);
    checkVal("discSingle", outWord0, 32'h20090000);
    checkVal("discSinglePc", outPc0, 32'h6000);
    drive(1, 0, 1, 16'h8E7F, 32'hFFFFFFFE, 1);
    drive(1, 0, 1, 16'hE001, 32'h00000000, 1);
    checkVal("wrapWord", outWord0, 32'hE0018E7F);
    checkVal("wrapPc", outPc0, 32'hFFFFFFFE);
    checkVal("wrapPair", outPair0, 1);

    drive(1, 0, 1, 16'h6012, 32'h7000, 1);
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 1, 16'h7777, 32'h7002, 0);
      checkVal("bpInReady", obsRdy0, 0);
      checkVal("bpHoldWord", outWord0, 32'h60120000);
      checkVal("bpHoldValid", outValid0, 1);
    end
    drive(1, 0, 1, 16'h7777, 32'h7002, 1);
    checkVal("bpRelReady", obsRdy0, 1);
    checkVal("bpRelWord", outWord0, 32'h77770000);
    checkVal("bpRelValid", outValid0, 1);

    drive(1, 0, 1, 16'h8E22, 32'h8000, 1);
    drive(1, 1, 0, 16'h0000, 32'h0, 1);
    checkVal("flushNoOut", outValid0, 0);
    drive(1, 0, 0, 16'h0000, 32'h0, 1);
    checkVal("flushStillNone", outValid0, 0);
    drive(1, 0, 1, 16'hE105, 32'h4000, 1);
    checkVal("postFlushWord", outWord0, 32'hE1050000);
    checkVal("postFlushPair", outPair0, 0);
    drive(1, 0, 1, 16'h1111, 32'h9000, 1);
    drive(1, 0, 0, 16'h0000, 32'h0, 0);
    drive(1, 1, 0, 16'h0000, 32'h0, 0);
    checkVal("flushStalled", outValid0, 0);

    curW = genWord();
    curPc = 32'h0001_0000;
    for (int i = 0; i < 800; i++) begin
      r = ($urandom_range(0, 149) != 0);
      f = ($urandom_range(0, 39) == 0);
      v = ($urandom_range(0, 3) != 0);
      o = ($urandom_range(0, 2) != 0);
      drive(r, f, v, curW, curPc, o);
      if (lastRdy[0] || $urandom_range(0, 15) == 0) begin
        curW = genWord();
        case ($urandom_range(0, 9))
          0: curPc = {$urandom, 1'b0} & 32'hFFFF_FFFE;
          1: curPc = 32'hFFFF_FFFC;
          default: curPc = curPc + 32'd2;
        endcase
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
